// File: rtl/mac_result_drain.sv
// mac_result_drain
//   Output stage of the MAC block. Each finished C result is captured, together
//   with its 2-bit mode tag, into a small FIFO. The results are then sent out
//   LSB-first as OUT_W-bit beats over a valid/ready stream. This keeps MAC
//   completion timing independent of a narrow output port that may apply
//   back-pressure.
//
// Parameters
//   ACC_WIDTH  width of a captured C result
//   OUT_W      beat width (ACC_WIDTH must be a multiple of OUT_W)
//   DEPTH      number of FIFO entries (power of 2, >= 2)
//
// Ports
//   clk, rst      clock and synchronous active-high reset
//   c_valid       c_in/c_tag carry a finished result in this cycle
//   c_in, c_tag   MAC result and its mode tag (tag 11 is passed through unchanged)
//   out_ready     consumer accepts the current beat
//   clr_overflow  clears the sticky overflow flag
//   out_valid     out_data holds a valid beat
//   out_data      current beat; the LSB slice is sent first
//   out_tag       tag of the word in flight
//   out_last      final beat of a word
//   full, empty   FIFO occupancy flags
//   overflow      sticky flag: a result was dropped because the FIFO was full
//   out_parity    XOR-reduce of out_data; exists only when MAC_DRAIN_PARITY_EN is defined
module mac_result_drain #(
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 c_valid,
  input  logic [ACC_WIDTH-1:0] c_in,
  input  logic [1:0]           c_tag,
  input  logic                 out_ready,
  input  logic                 clr_overflow,
  output logic                 out_valid,
  output logic [OUT_W-1:0]     out_data,
  output logic [1:0]           out_tag,
  output logic                 out_last,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow
`ifdef MAC_DRAIN_PARITY_EN
  ,
  output logic                 out_parity
`endif
);

  localparam int unsigned BEATS = ACC_WIDTH / OUT_W;
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state;
  logic [ACC_WIDTH+1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [ACC_WIDTH-1:0] shift;
  logic [ACC_WIDTH-1:0] shift_nxt;
  logic [IDX_W-1:0]     idx;
  logic [ACC_WIDTH-1:0] head_data;
  logic [1:0]           head_tag;
  logic                 do_write;
  logic                 do_pop;
  logic                 beat_done;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_write  = c_valid && !full;
  assign beat_done = (state == SEND) && out_valid && out_ready;
  // A pop happens from IDLE, or when the last beat is accepted, so that
  // consecutive words stream without a gap. Using the count from before the
  // clock edge means a word written in this cycle cannot be popped until the
  // next cycle.
  assign do_pop    = !empty && ((state == IDLE) || (beat_done && out_last));
  assign {head_tag, head_data} = mem[rd_ptr];
  assign shift_nxt = shift >> OUT_W;

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= {c_tag, c_in};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_write, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      // When a write is dropped and a clear arrives in the same cycle, the set wins.
      if (c_valid && full)   overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      idx        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tag    <= '0;
      out_last   <= 1'b0;
`ifdef MAC_DRAIN_PARITY_EN
      out_parity <= 1'b0;
`endif
    end else if (do_pop) begin
      state      <= SEND;
      shift      <= head_data;
      idx        <= '0;
      out_valid  <= 1'b1;
      out_data   <= head_data[OUT_W-1:0];
      out_tag    <= head_tag;
      out_last   <= (BEATS == 1);
`ifdef MAC_DRAIN_PARITY_EN
      out_parity <= ^head_data[OUT_W-1:0];
`endif
    end else if (beat_done && !out_last) begin
      shift      <= shift_nxt;
      idx        <= idx + IDX_W'(1);
      out_data   <= shift_nxt[OUT_W-1:0];
      out_last   <= (BEATS > 1) && (idx == IDX_W'(BEATS - 2));
`ifdef MAC_DRAIN_PARITY_EN
      out_parity <= ^shift_nxt[OUT_W-1:0];
`endif
    end else if (beat_done) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
    end
  end

endmodule
